// File: rtl/uart_reg_master.sv
// uart_reg_master: UART register-access master.
// Sends 3-byte command frames (addr, cmd, data) on tx and parses 8-byte
// A5/5A-framed replies on rx. A reply on channel 0xFE while a read is
// outstanding completes the read (rsp_*); any other frame is forwarded on frm_*.
// Optional feature: define UART_REG_MASTER_TIMEOUT_EN to give reads a reply
// timeout of TIMEOUT clk_50m cycles (rsp_err=1 on expiry).
module uart_reg_master #(
  parameter int DIV     = 434,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        frm_valid,
  output logic [7:0]  frm_chan,
  output logic [39:0] frm_data,
  output logic        tx,
  input  logic        rx
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'((DIV + 1) / 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} tx_state_t;
  typedef enum logic [1:0] {HUNT0, HUNT1, BODY}   rx_state_t;

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bit_q;
  logic [1:0]       tx_byte_q;
  logic [23:0]      tx_frame_q;
  logic             tx_wr_q;
  logic [7:0]       tx_cur;
  logic [3:0]       tx_didx;

  logic             rx_s1, rx_s2, rx_d;
  logic             rx_busy_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [3:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  rx_state_t        p_state_q, p_state_d;
  logic [2:0]       p_idx_q;
  logic [7:0]       chan_q;
  logic [31:0]      pay_q;

  logic accept, tx_bit_end, tx_last;
  logic rx_stop, byte_stb, frame_err, frame_done, reply_hit, to_hit;

  assign cmd_ready  = (tx_state_q == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  assign tx_last    = (tx_state_q == SEND) && tx_bit_end && (tx_bit_q == 4'd9) && (tx_byte_q == 2'd2);

  assign rx_stop    = rx_busy_q && (rx_bit_q == 4'd9) && (rx_cnt_q == BIT_LAST);
  assign byte_stb   = rx_stop && rx_s2;
  assign frame_err  = rx_stop && !rx_s2;
  assign frame_done = byte_stb && (p_state_q == BODY) && (p_idx_q == 3'd5);
  assign reply_hit  = frame_done && (chan_q == 8'hFE) && (tx_state_q == WAIT_RSP);

  // TX state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) tx_state_q <= IDLE;
    else     tx_state_q <= tx_state_d;
  end

  // TX next-state: command accept, end of third byte, reply or timeout.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      IDLE:     if (accept) tx_state_d = SEND;
      SEND:     if (tx_last) tx_state_d = tx_wr_q ? IDLE : WAIT_RSP;
      WAIT_RSP: if (reply_hit || to_hit) tx_state_d = IDLE;
      default:  tx_state_d = IDLE;
    endcase
  end

  // TX datapath: latch the frame on accept, then step cycle/bit/byte counters.
  // NOTE: the frame register has no memory semantics, so it is reset like any other flop.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      tx_frame_q <= '0;
      tx_wr_q    <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
    end else if (accept) begin
      tx_frame_q <= {cmd_wr ? cmd_wdata : 8'h00, cmd_wr ? 8'h00 : 8'h01, cmd_addr};
      tx_wr_q    <= cmd_wr;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
    end else if (tx_state_q == SEND) begin
      if (tx_bit_end) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == 4'd9) begin
          tx_bit_q  <= '0;
          tx_byte_q <= tx_byte_q + 2'd1;
        end else begin
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  // Serial line: start bit, 8 data bits LSB first, stop bit; idle high otherwise.
  always_comb begin
    case (tx_byte_q)
      2'd0:    tx_cur = tx_frame_q[7:0];
      2'd1:    tx_cur = tx_frame_q[15:8];
      default: tx_cur = tx_frame_q[23:16];
    endcase
    tx_didx = tx_bit_q - 4'd1;
    tx = 1'b1;
    if (tx_state_q == SEND) begin
      if (tx_bit_q == 4'd0)      tx = 1'b0;
      else if (tx_bit_q != 4'd9) tx = tx_cur[tx_didx[2:0]];
    end
  end

  // rx synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else     {rx_s1, rx_s2, rx_d} <= {rx, rx_s1, rx_s2};
  end

  // RX bit engine: start on falling edge, re-check start at half bit, sample mid-bit.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_busy_q  <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else if (!rx_busy_q) begin
      if (rx_d && !rx_s2) begin
        rx_busy_q <= 1'b1;
        rx_cnt_q  <= '0;
        rx_bit_q  <= '0;
      end
    end else if (rx_bit_q == 4'd0) begin
      if (rx_cnt_q == BIT_HALF) begin
        rx_cnt_q <= '0;
        if (!rx_s2) rx_bit_q  <= 4'd1;
        else        rx_busy_q <= 1'b0;
      end else begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end else if (rx_cnt_q == BIT_LAST) begin
      rx_cnt_q <= '0;
      if (rx_bit_q == 4'd9) begin
        rx_busy_q <= 1'b0;
      end else begin
        rx_shift_q <= {rx_s2, rx_shift_q[7:1]};
        rx_bit_q   <= rx_bit_q + 4'd1;
      end
    end else begin
      rx_cnt_q <= rx_cnt_q + 1'b1;
    end
  end

  // Parser state register.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) p_state_q <= HUNT0;
    else     p_state_q <= p_state_d;
  end

  // Parser next-state: hunt for A5 5A, then six body bytes; framing error rehunts.
  always_comb begin
    p_state_d = p_state_q;
    if (frame_err) begin
      p_state_d = HUNT0;
    end else if (byte_stb) begin
      case (p_state_q)
        HUNT0:   if (rx_shift_q == 8'hA5) p_state_d = HUNT1;
        HUNT1:   if (rx_shift_q == 8'h5A)      p_state_d = BODY;
                 else if (rx_shift_q != 8'hA5) p_state_d = HUNT0;
        BODY:    if (p_idx_q == 3'd5) p_state_d = HUNT0;
        default: p_state_d = HUNT0;
      endcase
    end
  end

  // Parser body capture: channel then payload bytes 0..3 (byte 4 comes straight from rx).
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      p_idx_q <= '0;
      chan_q  <= '0;
      pay_q   <= '0;
    end else if (byte_stb) begin
      if (p_state_q == HUNT1) begin
        p_idx_q <= '0;
      end else if (p_state_q == BODY) begin
        p_idx_q <= p_idx_q + 3'd1;
        case (p_idx_q)
          3'd0:    chan_q        <= rx_shift_q;
          3'd1:    pay_q[7:0]    <= rx_shift_q;
          3'd2:    pay_q[15:8]   <= rx_shift_q;
          3'd3:    pay_q[23:16]  <= rx_shift_q;
          3'd4:    pay_q[31:24]  <= rx_shift_q;
          default: ;
        endcase
      end
    end
  end

`ifdef UART_REG_MASTER_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        rsp_err_q;

  assign to_hit  = (tx_state_q == WAIT_RSP) && (to_cnt_q == 32'(TIMEOUT - 1)) && !reply_hit;
  assign rsp_err = rsp_err_q;

  // Reply timeout counter, cleared whenever no read is outstanding.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)                         to_cnt_q <= '0;
    else if (tx_state_q != WAIT_RSP) to_cnt_q <= '0;
    else                             to_cnt_q <= to_cnt_q + 32'd1;
  end

  // Error flag accompanies rsp_valid and holds until the next response.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)            rsp_err_q <= 1'b0;
    else if (reply_hit) rsp_err_q <= 1'b0;
    else if (to_hit)    rsp_err_q <= 1'b1;
  end
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Output pulses: read completion, forwarded frame, or timeout; data holds between pulses.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      frm_valid <= 1'b0;
      frm_chan  <= '0;
      frm_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      frm_valid <= 1'b0;
      if (reply_hit) begin
        rsp_valid <= 1'b1;
        rsp_data  <= pay_q[7:0];
      end else if (frame_done) begin
        frm_valid <= 1'b1;
        frm_chan  <= chan_q;
        frm_data  <= {rx_shift_q, pay_q};
      end else if (to_hit) begin
        rsp_valid <= 1'b1;
        rsp_data  <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master: scoreboard bench for uart_reg_master.
// Stimulus pushes expected tx bytes and expected rsp/frm pulses into queues;
// independent monitors decode tx and pop/compare on every output pulse.
// Define UART_REG_MASTER_TIMEOUT_EN to include the read-timeout scenario.
module tb_uart_reg_master;

  localparam int DIV     = 15;
  localparam int TIMEOUT = 1000;
  localparam int BIT     = DIV + 1;
  localparam int CMD_CYC = 30 * BIT;

  logic        clk_50m;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        frm_valid;
  logic [7:0]  frm_chan;
  logic [39:0] frm_data;
  logic        tx;
  logic        rx;

  uart_reg_master #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .frm_valid(frm_valid),
    .frm_chan (frm_chan),
    .frm_data (frm_data),
    .tx       (tx),
    .rx       (rx)
  );

  initial begin
    clk_50m = 1'b0;
    forever #5 clk_50m = ~clk_50m;
  end

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          is_rsp;
    logic [7:0]  data;
    logic        err;
    logic [7:0]  chan;
    logic [39:0] fdata;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tx_exp[$];
  bit         tx_mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input logic [7:0] d, input logic e, input int c);
    exp_t x;
    x.is_rsp = 1'b1; x.data = d; x.err = e; x.chan = '0; x.fdata = '0; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic push_frm(input logic [7:0] ch, input logic [39:0] d);
    exp_t x;
    x.is_rsp = 1'b0; x.data = '0; x.err = 1'b0; x.chan = ch; x.fdata = d; x.cyc = -1;
    sb.push_back(x);
  endtask

  // Pulse monitor: every rsp/frm pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50m);
      if (!rst && (rsp_valid || frm_valid)) begin
        check("pulse_exclusive", rsp_valid && frm_valid, 1'b0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {rsp_valid, frm_valid}, 2'b00);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_rsp", rsp_valid, e.is_rsp);
          if (e.is_rsp) begin
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", rsp_err, e.err);
            check("cmd_ready_at_rsp", cmd_ready, 1'b1);
            if (e.cyc >= 0) check("rsp_latency_cycle", cyc, e.cyc);
            @(negedge clk_50m);
            check("rsp_one_cycle", rsp_valid, 1'b0);
            check("cmd_ready_after_rsp", cmd_ready, 1'b1);
          end else begin
            check("frm_chan", frm_chan, e.chan);
            check("frm_data", frm_data, e.fdata);
            @(negedge clk_50m);
            check("frm_one_cycle", frm_valid, 1'b0);
          end
        end
      end
    end
  end

  // TX monitor: decodes each byte at mid-bit and compares with the expected queue.
  initial begin
    int         last_start;
    int         st;
    logic [7:0] b;
    logic       sbit, pbit;
    last_start = -100000;
    forever begin
      @(negedge tx);
      repeat (BIT / 2) @(posedge clk_50m);
      #1;
      st   = cyc;
      sbit = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(posedge clk_50m);
        #1 b[i] = tx;
      end
      repeat (BIT) @(posedge clk_50m);
      #1 pbit = tx;
      if (tx_mon_en) begin
        check("tx_start_bit", sbit, 1'b0);
        check("tx_stop_bit", pbit, 1'b1);
        if (st - last_start < 10 * BIT + BIT / 2) check("tx_byte_spacing", st - last_start, 10 * BIT);
        last_start = st;
        if (tx_exp.size() == 0) check("tx_byte_expected", tx_exp.size() > 0, 1'b1);
        else                    check("tx_byte", b, tx_exp.pop_front());
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wd, output int acc);
    int n;
    n = 0;
    tx_exp.push_back(addr);
    tx_exp.push_back(wr ? 8'h00 : 8'h01);
    tx_exp.push_back(wr ? wd : 8'h00);
    @(negedge clk_50m);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk_50m);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_bound", cmd_ready, 1'b1);
    @(posedge clk_50m);
    #1 cmd_valid = 1'b0;
    @(negedge clk_50m);
    acc = cyc;
    check("tx_start_after_accept", tx, 1'b0);
  endtask

  task automatic wait_ready(input int budget, output int c);
    int n;
    n = 0;
    @(negedge clk_50m);
    while (!cmd_ready && n < budget) begin
      @(negedge clk_50m);
      n++;
    end
    check("cmd_ready_return_bound", cmd_ready, 1'b1);
    c = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    @(posedge clk_50m);
    #2 rx = 1'b0;
    repeat (BIT) @(posedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      #2 rx = b[i];
      repeat (BIT) @(posedge clk_50m);
    end
    #2 rx = stop_v;
    repeat (BIT) @(posedge clk_50m);
    #2 rx = 1'b1;
    if (!stop_v) repeat (BIT) @(posedge clk_50m);
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [39:0] pl);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(ch, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(pl[8*k +: 8], 1'b1);
  endtask

  initial begin
    int acc, acc2, c, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rx = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk_50m);
    check("rst_tx", tx, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_frm_valid", frm_valid, 1'b0);
    check("rst_frm_chan", frm_chan, 8'h00);
    check("rst_frm_data", frm_data, 40'h0);
    rst = 1'b0;
    #1 check("ready_after_reset", cmd_ready, 1'b1);

    // Write 0x12 <- 0x3C: three bytes, no response pulse.
    do_cmd(1'b1, 8'h12, 8'h3C, acc);
    wait_ready(2 * CMD_CYC, c);
    check("write_duration", c - acc, CMD_CYC);
    repeat (2 * BIT) @(posedge clk_50m);

    // Read 0x05, slave replies on channel FE with 0x77.
    do_cmd(1'b0, 8'h05, 8'h00, acc);
    repeat (CMD_CYC + BIT) @(posedge clk_50m);
    @(negedge clk_50m);
    check("cmd_ready_in_wait_rsp", cmd_ready, 1'b0);
    push_rsp(8'h77, 1'b0, -1);
    send_frame(8'hFE, 40'h0000000077);
    wait_ready(20 * BIT, c);
    repeat (2 * BIT) @(posedge clk_50m);

    // Unsolicited frame while idle.
    push_frm(8'h02, 40'h0504030201);
    send_frame(8'h02, 40'h0504030201);
    repeat (2 * BIT) @(posedge clk_50m);

    // Channel FE with no read outstanding is just a frame.
    push_frm(8'hFE, 40'h1122334455);
    send_frame(8'hFE, 40'h1122334455);
    repeat (2 * BIT) @(posedge clk_50m);

    // Garbage and repeated A5 before the header.
    push_frm(8'h06, 40'h5040302010);
    send_byte(8'h33, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_frame(8'h06, 40'h5040302010);
    repeat (2 * BIT) @(posedge clk_50m);

    // Framing error mid-frame: no pulse; next clean frame accepted.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    push_frm(8'h07, 40'hEEDDCCBBAA);
    send_frame(8'h07, 40'hEEDDCCBBAA);
    repeat (2 * BIT) @(posedge clk_50m);

    // Frame arriving while a write is being transmitted.
    push_frm(8'h03, 40'h0A0B0C0D0E);
    fork
      do_cmd(1'b1, 8'h40, 8'h99, acc2);
      send_frame(8'h03, 40'h0A0B0C0D0E);
    join
    wait_ready(2 * CMD_CYC, c);
    repeat (2 * BIT) @(posedge clk_50m);

`ifdef UART_REG_MASTER_TIMEOUT_EN
    // Read with no reply times out; a late reply becomes a frame.
    do_cmd(1'b0, 8'h30, 8'h00, acc);
    push_rsp(8'h00, 1'b1, acc + CMD_CYC + TIMEOUT);
    wait_ready(CMD_CYC + TIMEOUT + 100, c);
    repeat (2 * BIT) @(posedge clk_50m);
    push_frm(8'hFE, 40'h00000000AB);
    send_frame(8'hFE, 40'h00000000AB);
    repeat (2 * BIT) @(posedge clk_50m);
`endif

    // Reset during the first byte of a read abandons it.
    do_cmd(1'b0, 8'h21, 8'h00, acc);
    repeat (5 * BIT) @(posedge clk_50m);
    tx_mon_en = 1'b0;
    @(negedge clk_50m);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    repeat (2) @(negedge clk_50m);
    check("midrst_frm_chan", frm_chan, 8'h00);
    check("midrst_frm_data", frm_data, 40'h0);
    check("midrst_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;
    #1 check("midrst_ready_after_release", cmd_ready, 1'b1);
    tx_exp.delete();
    repeat (20 * BIT) @(posedge clk_50m);
    tx_mon_en = 1'b1;
    do_cmd(1'b1, 8'h55, 8'hAA, acc);
    wait_ready(2 * CMD_CYC, c);
    check("post_reset_write_duration", c - acc, CMD_CYC);

    // Drain outstanding expectations.
    n = 0;
    while ((sb.size() != 0 || tx_exp.size() != 0) && n < 5000) begin
      @(negedge clk_50m);
      n++;
    end
    repeat (4 * BIT) @(negedge clk_50m);
    check("scoreboard_drained", sb.size(), 0);
    check("tx_queue_drained", tx_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
